// File: rtl/counter_stim_pkg.sv
// Shared types and constants for the loadable-counter stimulus driver.
// Used by counter_stim_driver and stim_lfsr; see counter_stim_driver for the STIM_WRAP_EN option.
package counter_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_INC  = 2'd1;
    localparam logic [1:0] OP_LD   = 2'd2;

    // x^8+x^6+x^5+x^4+1 expressed as the bits XORed into the shift-left input
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int unsigned CNT_W = 3;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned CNT_MAX = cnt_max(CNT_W);

endpackage

// File: rtl/stim_lfsr.sv
// 8-bit Fibonacci LFSR: shifts left with feedback into bit 0, reloads SEED on reset.
// Exposes only the bit fields the driver decodes ops from.
module stim_lfsr
    import counter_stim_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [1:0] op_bits,
    output logic [2:0] load_bits
);

    logic [7:0] value_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= SEED;
        end else if (adv) begin
            value_q <= {value_q[6:0], ^(value_q & LFSR_TAPS)};
        end
    end

    assign op_bits   = value_q[1:0];
    assign load_bits = value_q[7:5];

endmodule

// File: rtl/counter_stim_driver.sv
// Pseudo-random legal ld/inc driver for the loadable counter, with a shadow-model compare.
// Define STIM_WRAP_EN to allow increments at the maximum count (wrapping counter variants).
module counter_stim_driver
    import counter_stim_pkg::*;
#(
    parameter int unsigned WIDTH     = CNT_W,
    parameter int unsigned NUM_OPS_W = 8,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_OPS_W-1:0] num_ops,
    output logic                 busy,
    output logic                 done,
    output logic                 ld,
    output logic                 inc,
    output logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     data_out,
    output logic                 mismatch,
    output logic [7:0]           err_count
);

`ifndef STIM_WRAP_EN
    localparam logic [WIDTH-1:0] SHADOW_MAX = WIDTH'(cnt_max(WIDTH));
`endif

    state_t               state_q, state_d;
    logic [NUM_OPS_W-1:0] ops_left_q;
    logic [WIDTH-1:0]     shadow_q;
    logic                 shadow_valid_q;
    logic [1:0]           op;
    logic [WIDTH-1:0]     load_val;
    logic                 lfsr_adv;
    logic [1:0]           lfsr_op_bits;
    logic [2:0]           lfsr_load_bits;
    logic                 compare_en;
    logic                 miscompare;

    stim_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .adv       (lfsr_adv),
        .op_bits   (lfsr_op_bits),
        .load_bits (lfsr_load_bits)
    );

    always_comb begin
        state_d  = state_q;
        op       = OP_IDLE;
        load_val = '0;
        lfsr_adv = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                op      = OP_LD;
                state_d = (ops_left_q != '0) ? RUN : DRAIN;
            end
            RUN: begin
                lfsr_adv = 1'b1;
                load_val = WIDTH'(lfsr_load_bits);
                case (lfsr_op_bits)
                    2'b00:   op = OP_IDLE;
                    2'b11:   op = OP_LD;
                    default: op = OP_INC;
                endcase
`ifndef STIM_WRAP_EN
                // An increment at the top of the range would break the counter's rule, so reload instead
                if (op == OP_INC && shadow_q == SHADOW_MAX) op = OP_LD;
`endif
                if (ops_left_q == NUM_OPS_W'(1)) state_d = DRAIN;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ld      = (op == OP_LD);
    assign inc     = (op == OP_INC);
    assign data_in = ld ? load_val : '0;
    assign busy    = (state_q == INIT) || (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

    // data_out lags the op by one edge, so it is checked against the shadow value held before this cycle's op
    assign compare_en = shadow_valid_q &&
                        ((state_q == RUN) || (state_q == DRAIN) || (state_q == DONE));
    assign miscompare = compare_en && (data_out != shadow_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            ops_left_q     <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            mismatch       <= 1'b0;
            err_count      <= 8'd0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && start) begin
                ops_left_q <= num_ops;
                mismatch   <= 1'b0;
                err_count  <= 8'd0;
            end else if (miscompare) begin
                mismatch <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end

            if (state_q == RUN) ops_left_q <= ops_left_q - NUM_OPS_W'(1);
            if (state_q == INIT) shadow_valid_q <= 1'b1;

            if (ld) begin
                shadow_q <= data_in;
            end else if (inc) begin
                shadow_q <= shadow_q + WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/counter_stim_driver.md
Name: counter_stim_driver

Overview:
- Initiator side for the 3-bit loadable counter interface (ld, inc, data_in, data_out).
- Drives a pseudo-random, rule-legal sequence of load, increment and idle ops into the counter.
- Keeps a shadow model of the expected count and compares it against data_out every cycle.
- Sits in the testbench/FPGA self-test harness beside the counter and its assertion checker.
- Legal means never asserting inc while the count is at maximum.

Parameters:
- WIDTH, 3: counter data width.
- NUM_OPS_W, 8: width of the op-count request.
- SEED, 8'hA5: LFSR reset seed. Must be nonzero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE
- num_ops  input  NUM_OPS_W  number of RUN cycles; captured on start
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse at end of run
- ld  output  1  counter load strobe
- inc  output  1  counter increment strobe
- data_in  output  WIDTH  load value, valid when ld=1, else 0
- data_out  input  WIDTH  counter value
- mismatch  output  1  sticky compare-failure flag
- err_count  output  8  saturating count of mismatching cycles

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; ld, inc, data_in, busy, done, mismatch, err_count all 0.
  - LFSR=SEED; op counter=0; shadow valid=0.
  - Takes effect from any state, including mid-run; no drain, no done pulse.
- Counter timing: the counter updates on the same edge that samples ld/inc, so data_out reflects an op one cycle later. The shadow register updates on that same edge.
- States:
  - IDLE: start=1 → INIT. Clear mismatch and err_count, capture num_ops, busy=1 next cycle. start while busy is ignored.
  - INIT: one cycle. ld=1, data_in=0, shadow←0, shadow valid←1. → RUN if num_ops≠0, else DRAIN.
  - RUN: one op per cycle; LFSR advances every RUN cycle.
    - lfsr[1:0]=00: idle (ld=inc=0).
    - lfsr[1:0]=01 or 10: inc; shadow←shadow+1.
    - lfsr[1:0]=11: ld with data_in=lfsr[7:5]; shadow←that value.
    - If the choice is inc and shadow==2^WIDTH−1: convert to ld of lfsr[7:5] (see macro).
    - After num_ops RUN cycles → DRAIN.
  - DRAIN: one cycle, ld=inc=0, final compare. → DONE.
  - DONE: done=1 for one cycle, busy=0. → IDLE.
- Ld and inc are never asserted together.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift-left, feedback into bit 0. Used only in RUN.
- Compare:
  - Active in every cycle with shadow valid=1 and state ∈ {RUN, DRAIN, DONE}.
  - Condition: data_out≠shadow_q, where shadow_q is the shadow value before this cycle's op.
  - On mismatch: mismatch←1 (sticky until the next start); err_count+1, saturating at 255.
- Width rules: shadow is WIDTH bits. Increment arithmetic is modulo 2^WIDTH only when wrap is enabled.

Optional Feature:
- Macro: STIM_WRAP_EN.
- Defined: inc at max is legal and is issued as chosen; shadow wraps 7→0. Used for wrapping counter variants with the assertion disabled.
- Undefined (default): inc at max is converted to ld as described above. The driver never violates the no-increment-at-max rule.

Decomposition:
- Package counter_stim_pkg:
  - state enum: IDLE, INIT, RUN, DRAIN, DONE.
  - op encoding constants: OP_IDLE, OP_INC, OP_LD.
  - LFSR tap mask 8'hB8.
  - CNT_MAX.
- Sub-module stim_lfsr: 8-bit LFSR with seed load on reset and an advance enable.

Test Plan:
1. Reset: rst=0 for 2 cycles mid-idle → ld=inc=busy=done=mismatch=0, err_count=0; first RUN op decodes from LFSR value 8'hA5 (lfsr[1:0]=01 → inc).
2. start, num_ops=0, correct counter → INIT ld=1 data_in=0, then DRAIN; done pulses exactly 3 cycles after start is sampled; err_count=0.
3. start, num_ops=200, correct counter, macro undefined → 200 RUN cycles, inc never high while data_out==7, assertion checker silent, err_count=0, mismatch=0.
4. Counter with data_out bit0 stuck-at-1, num_ops=255 → mismatch=1 from the first even shadow value onward, err_count>0; with data_out forced to a constant, err_count saturates at 255.
5. rst=0 at RUN cycle 50 → next cycle all outputs 0, IDLE; restart with the same num_ops → identical ld/inc/data_in sequence to the first run.
6. STIM_WRAP_EN defined, wrapping counter → inc issued at data_out=7, next data_out=0, err_count=0.
